// File: rtl/clk_div_bank.sv
// NUM_CH independent programmable square-wave dividers with rise/fall strobes; outputs registered (1-cycle).
// Config writes stall per channel while a previous value is still pending; new HP lands only at a fall, disable or sync.
module clk_div_bank #(
    parameter int NUM_CH     = 2,
    parameter int CNT_W      = 8,
    parameter int CH_W       = 4,
    parameter int DEFAULT_HP = 14
) (
    input  logic              clk150M_in,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_hp,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] rise_tick,
    output logic [NUM_CH-1:0] fall_tick
);

    logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_CH-1:0][CNT_W-1:0] hp_act_q, hp_act_d;
    logic [NUM_CH-1:0][CNT_W-1:0] hp_pend_q, hp_pend_d;
    logic [NUM_CH-1:0]            pend_q, pend_d;
    logic [NUM_CH-1:0]            out_q, out_d;
    logic [NUM_CH-1:0]            rise_q, rise_d;
    logic [NUM_CH-1:0]            fall_q, fall_d;

    // Out-of-range channels never match, so such writes are accepted and dropped.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = ~pend_q[i];
            end
        end
    end

    always_comb begin
        cnt_d     = cnt_q;
        hp_act_d  = hp_act_q;
        hp_pend_d = hp_pend_q;
        pend_d    = pend_q;
        out_d     = out_q;
        rise_d    = '0;
        fall_d    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sync || !ch_en[i]) begin
                cnt_d[i] = '0;
                out_d[i] = 1'b0;
                if (pend_q[i]) begin
                    hp_act_d[i] = hp_pend_q[i];
                    pend_d[i]   = 1'b0;
                end
            end else if (cnt_q[i] == hp_act_q[i]) begin
                cnt_d[i]  = '0;
                out_d[i]  = ~out_q[i];
                rise_d[i] = ~out_q[i];
                fall_d[i] = out_q[i];
                // Only a falling edge may swap HP, so the high half is never cut short.
                if (out_q[i] && pend_q[i]) begin
                    hp_act_d[i] = hp_pend_q[i];
                    pend_d[i]   = 1'b0;
                end
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
            if (cfg_valid && cfg_ready && cfg_ch == CH_W'(i)) begin
                hp_pend_d[i] = cfg_hp;
                pend_d[i]    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk150M_in) begin
        if (rst) begin
            cnt_q     <= '0;
            hp_act_q  <= {NUM_CH{CNT_W'(DEFAULT_HP)}};
            hp_pend_q <= '0;
            pend_q    <= '0;
            out_q     <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
        end else begin
            cnt_q     <= cnt_d;
            hp_act_q  <= hp_act_d;
            hp_pend_q <= hp_pend_d;
            pend_q    <= pend_d;
            out_q     <= out_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
        end
    end

    assign clk_out   = out_q;
    assign rise_tick = rise_q;
    assign fall_tick = fall_q;

endmodule

// File: tb/tb_clk_div_bank.sv
// Randomized bench for clk_div_bank against a countdown-based behavioural model.
module tb_clk_div_bank;

    localparam int NUM_CH = 2;
    localparam int CNT_W  = 8;
    localparam int CH_W   = 4;
    localparam int DEF_HP = 14;
    localparam int NCYC   = 8000;

    logic              clk150M_in;
    logic              rst;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_hp;
    logic [NUM_CH-1:0] ch_en;
    logic              sync;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] rise_tick;
    logic [NUM_CH-1:0] fall_tick;

    clk_div_bank #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .CH_W(CH_W), .DEFAULT_HP(DEF_HP)
    ) dut (
        .clk150M_in(clk150M_in), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_hp(cfg_hp),
        .ch_en(ch_en), .sync(sync),
        .clk_out(clk_out), .rise_tick(rise_tick), .fall_tick(fall_tick)
    );

    initial clk150M_in = 1'b0;
    always #5 clk150M_in = ~clk150M_in;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: each channel counts down the cycles left in its current half.
    int rem   [NUM_CH];
    int hp    [NUM_CH];
    int hpp   [NUM_CH];
    bit pd    [NUM_CH];
    bit lvl   [NUM_CH];
    bit m_r   [NUM_CH];
    bit m_f   [NUM_CH];

    function automatic bit model_ready(input int ch);
        if (ch < NUM_CH) return !pd[ch];
        return 1'b1;
    endfunction

    task automatic model_step(input bit r, input bit s, input logic [NUM_CH-1:0] en,
                              input bit acc, input int ch, input int newhp);
        for (int i = 0; i < NUM_CH; i++) begin
            m_r[i] = 0;
            m_f[i] = 0;
            if (r) begin
                hp[i] = DEF_HP; pd[i] = 0; lvl[i] = 0; rem[i] = DEF_HP + 1;
            end else if (s || !en[i]) begin
                lvl[i] = 0;
                if (pd[i]) begin hp[i] = hpp[i]; pd[i] = 0; end
                rem[i] = hp[i] + 1;
            end else begin
                rem[i]--;
                if (rem[i] == 0) begin
                    if (lvl[i]) begin
                        m_f[i] = 1; lvl[i] = 0;
                        if (pd[i]) begin hp[i] = hpp[i]; pd[i] = 0; end
                    end else begin
                        m_r[i] = 1; lvl[i] = 1;
                    end
                    rem[i] = hp[i] + 1;
                end
            end
        end
        if (!r && acc && ch < NUM_CH) begin
            hpp[ch] = newhp;
            pd[ch]  = 1;
        end
    endtask

    function automatic logic [NUM_CH-1:0] pack(input bit v [NUM_CH]);
        logic [NUM_CH-1:0] p;
        for (int i = 0; i < NUM_CH; i++) p[i] = v[i];
        return p;
    endfunction

    initial begin
        logic [NUM_CH-1:0] en_st;
        bit acc;
        rst = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_hp = '0; ch_en = '1; sync = 1'b0;
        en_st = '1;
        repeat (2) begin
            @(posedge clk150M_in);
            model_step(1'b1, 1'b0, ch_en, 1'b0, 0, 0);
        end
        @(negedge clk150M_in);
        chk("rst_clk_out", 32'(clk_out), 32'd0);
        chk("rst_rise", 32'(rise_tick), 32'd0);
        chk("rst_fall", 32'(fall_tick), 32'd0);
        chk("rst_ready", 32'(cfg_ready), 32'd1);

        for (int c = 0; c < NCYC; c++) begin
            if (c > 0) begin
                @(negedge clk150M_in);
                chk("clk_out", 32'(clk_out), 32'(pack(lvl)));
                chk("rise_tick", 32'(rise_tick), 32'(pack(m_r)));
                chk("fall_tick", 32'(fall_tick), 32'(pack(m_f)));
            end
            if (c < 80) begin
                rst = 1'b0; sync = 1'b0; cfg_valid = 1'b0; ch_en = '1;
            end else begin
                rst  = ($urandom_range(0, 1499) == 0);
                sync = ($urandom_range(0, 199) == 0);
                for (int i = 0; i < NUM_CH; i++)
                    if ($urandom_range(0, 99) < 2) en_st[i] = ~en_st[i];
                ch_en     = en_st;
                cfg_valid = ($urandom_range(0, 7) == 0);
                cfg_ch    = CH_W'($urandom_range(0, 5));
                cfg_hp    = ($urandom_range(0, 9) == 0) ? CNT_W'($urandom_range(0, 200))
                                                        : CNT_W'($urandom_range(0, 6));
            end
            #1;
            chk("cfg_ready", 32'(cfg_ready), 32'(model_ready(int'(cfg_ch))));
            acc = cfg_valid && model_ready(int'(cfg_ch));
            @(posedge clk150M_in);
            model_step(rst, sync, ch_en, acc, int'(cfg_ch), int'(cfg_hp));
        end
        @(negedge clk150M_in);
        chk("clk_out_end", 32'(clk_out), 32'(pack(lvl)));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
